// File: rtl/clk_lock_supervisor.sv
// Qualifies the clock wizard's asynchronous lock flag against clk100 and sequences
// the design reset, recording lock-loss events and per-run uptime for bring-up.
module clk_lock_supervisor #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 256,
  parameter int CNT_W         = 16
) (
  input  logic        clk100,
  input  logic        rst_n,
  input  logic        locked,
  input  logic        clear_stats,
  output logic        sys_rst_n,
  output logic        ready_pulse,
  output logic [1:0]  state_o,
  output logic [15:0] lock_loss_cnt,
  output logic [31:0] uptime
);

  typedef enum logic [1:0] {
    ST_UNUSED    = 2'b00,
    ST_WAIT_LOCK = 2'b01,
    ST_HOLD      = 2'b10,
    ST_RUN       = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   locked_s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sys_rst_n_q, sys_rst_n_d;
  logic                   ready_pulse_q, ready_pulse_d;
  logic [15:0]            lock_loss_q, lock_loss_d;
  logic [31:0]            uptime_q, uptime_d;
  logic                   loss_event;

  // Oldest stage of the shift chain is the qualified lock flag.
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], locked};
  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sys_rst_n_d   = 1'b0;
    ready_pulse_d = 1'b0;
    uptime_d      = uptime_q;
    lock_loss_d   = lock_loss_q;
    loss_event    = 1'b0;

    case (state_q)
      ST_WAIT_LOCK: begin
        if (!locked_s) begin
          cnt_d = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        // Dropping lock before the design was released is not a lock loss.
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d       = ST_RUN;
          cnt_d         = '0;
          sys_rst_n_d   = 1'b1;
          ready_pulse_d = 1'b1;
          uptime_d      = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d    = ST_WAIT_LOCK;
          cnt_d      = '0;
          loss_event = 1'b1;
        end else begin
          sys_rst_n_d = 1'b1;
          uptime_d    = uptime_q + 32'd1;
        end
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase

    if (loss_event && (lock_loss_q != 16'hFFFF)) begin
      lock_loss_d = lock_loss_q + 16'd1;
    end

    // A clear coinciding with a loss still records that loss.
    if (clear_stats) begin
      lock_loss_d = {15'd0, loss_event};
      uptime_d    = '0;
    end
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= '0;
      state_q       <= ST_WAIT_LOCK;
      cnt_q         <= '0;
      sys_rst_n_q   <= 1'b0;
      ready_pulse_q <= 1'b0;
      lock_loss_q   <= '0;
      uptime_q      <= '0;
    end else begin
      sync_q        <= sync_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sys_rst_n_q   <= sys_rst_n_d;
      ready_pulse_q <= ready_pulse_d;
      lock_loss_q   <= lock_loss_d;
      uptime_q      <= uptime_d;
    end
  end

  assign sys_rst_n     = sys_rst_n_q;
  assign ready_pulse   = ready_pulse_q;
  assign state_o       = state_q;
  assign lock_loss_cnt = lock_loss_q;
  assign uptime        = uptime_q;

endmodule

// File: tb/tb_clk_lock_supervisor.sv
// Directed bench for clk_lock_supervisor: the driver pushes hand-computed expected
// outputs per checked edge; a negedge monitor pops and compares them.
module tb_clk_lock_supervisor;

  localparam int SYNC   = 2;
  localparam int STABLE = 8;
  localparam int HOLD   = 4;

  logic        clk100;
  logic        rst_n;
  logic        locked;
  logic        clear_stats;
  logic        sys_rst_n;
  logic        ready_pulse;
  logic [1:0]  state_o;
  logic [15:0] lock_loss_cnt;
  logic [31:0] uptime;

  logic [51:0] exp_q[$];
  string       name_q[$];
  int          n_checks;
  int          n_fail;

  clk_lock_supervisor #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .HOLD_CYCLES  (HOLD),
    .CNT_W        (16)
  ) dut (
    .clk100       (clk100),
    .rst_n        (rst_n),
    .locked       (locked),
    .clear_stats  (clear_stats),
    .sys_rst_n    (sys_rst_n),
    .ready_pulse  (ready_pulse),
    .state_o      (state_o),
    .lock_loss_cnt(lock_loss_cnt),
    .uptime       (uptime)
  );

  // Clock / watchdog
  initial clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach its end, got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  task automatic cmp(input string nm, input string fld, input logic [31:0] got,
                     input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s.%s got=%0h exp=%0h", nm, fld, got, want);
    end
  endtask

  // Monitor: one expectation per checked edge, compared mid-cycle
  always @(negedge clk100) begin
    if (exp_q.size() > 0) begin
      logic [51:0] e;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      cmp(nm, "sys_rst_n",     {31'd0, sys_rst_n},     {31'd0, e[51]});
      cmp(nm, "ready_pulse",   {31'd0, ready_pulse},   {31'd0, e[50]});
      cmp(nm, "state_o",       {30'd0, state_o},       {30'd0, e[49:48]});
      cmp(nm, "lock_loss_cnt", {16'd0, lock_loss_cnt}, {16'd0, e[47:32]});
      cmp(nm, "uptime",        uptime,                 e[31:0]);
    end
  end

  // Driver tasks
  task automatic adv(input int n);
    repeat (n) @(posedge clk100);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic srn, input logic rdy,
                            input logic [1:0] st, input logic [15:0] loss,
                            input logic [31:0] up);
    exp_q.push_back({srn, rdy, st, loss, up});
    name_q.push_back(nm);
  endtask

  // locked is already high; the next edge is edge 1 of qualification.
  task automatic lock_seq(input string nm, input logic [15:0] loss, input logic [31:0] up);
    adv(1);  expect_out({nm, "_e1"},  1'b0, 1'b0, 2'b01, loss, up);
    adv(8);  expect_out({nm, "_e9"},  1'b0, 1'b0, 2'b01, loss, up);
    adv(1);  expect_out({nm, "_e10"}, 1'b0, 1'b0, 2'b10, loss, up);
    adv(3);  expect_out({nm, "_e13"}, 1'b0, 1'b0, 2'b10, loss, up);
    adv(1);  expect_out({nm, "_e14"}, 1'b1, 1'b1, 2'b11, loss, 32'd0);
    adv(1);  expect_out({nm, "_e15"}, 1'b1, 1'b0, 2'b11, loss, 32'd1);
  endtask

  // Drop lock from RUN; up_held is the uptime at the loss edge.
  task automatic lose(input string nm, input logic [15:0] prev_loss,
                      input logic [15:0] new_loss, input logic [31:0] up_held);
    locked = 1'b0;
    adv(2);  expect_out({nm, "_j1"},   1'b1, 1'b0, 2'b11, prev_loss, up_held);
    adv(1);  expect_out({nm, "_j2"},   1'b0, 1'b0, 2'b01, new_loss, up_held);
    adv(3);  expect_out({nm, "_held"}, 1'b0, 1'b0, 2'b01, new_loss, up_held);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    locked      = 1'b0;
    clear_stats = 1'b0;

    adv(2);
    expect_out("reset", 1'b0, 1'b0, 2'b01, 16'd0, 32'd0);
    rst_n = 1'b1;
    adv(2);

    // Glitch in the stable window: one low sample after cnt reaches 5
    locked = 1'b1;
    adv(1);  expect_out("glitch_e1", 1'b0, 1'b0, 2'b01, 16'd0, 32'd0);
    adv(6);
    locked = 1'b0;
    adv(1);
    locked = 1'b1;
    adv(2);  expect_out("glitch_e10", 1'b0, 1'b0, 2'b01, 16'd0, 32'd0);
    adv(7);  expect_out("glitch_e17", 1'b0, 1'b0, 2'b01, 16'd0, 32'd0);
    adv(1);  expect_out("glitch_e18", 1'b0, 1'b0, 2'b10, 16'd0, 32'd0);

    // Asynchronous reset between edges while in HOLD
    adv(2);
    rst_n = 1'b0;
    expect_out("async_rst", 1'b0, 1'b0, 2'b01, 16'd0, 32'd0);
    adv(2);
    rst_n = 1'b1;
    lock_seq("clean", 16'd0, 32'd0);

    // Loss after 100 cycles in RUN
    adv(97); expect_out("run98", 1'b1, 1'b0, 2'b11, 16'd0, 32'd98);
    lose("loss1", 16'd0, 16'd1, 32'd100);
    locked = 1'b1;
    lock_seq("relock", 16'd1, 32'd100);

    for (int i = 1; i < 5; i++) begin
      lose("lossn", 16'(i), 16'(i + 1), 32'd3);
      locked = 1'b1;
      lock_seq("relockn", 16'(i + 1), 32'd3);
    end

    // Clear on the same edge as a loss
    locked = 1'b0;
    adv(2);  expect_out("coll_j1", 1'b1, 1'b0, 2'b11, 16'd5, 32'd3);
    clear_stats = 1'b1;
    adv(1);  expect_out("coll_j2", 1'b0, 1'b0, 2'b01, 16'd1, 32'd0);
    clear_stats = 1'b0;
    locked = 1'b1;
    lock_seq("relock_c", 16'd1, 32'd0);

    // Clear alone in RUN
    adv(4);  expect_out("clr_pre", 1'b1, 1'b0, 2'b11, 16'd1, 32'd5);
    clear_stats = 1'b1;
    adv(1);  expect_out("clr_0", 1'b1, 1'b0, 2'b11, 16'd0, 32'd0);
    clear_stats = 1'b0;
    adv(1);  expect_out("clr_1", 1'b1, 1'b0, 2'b11, 16'd0, 32'd1);
    adv(1);  expect_out("clr_2", 1'b1, 1'b0, 2'b11, 16'd0, 32'd2);

    // Uptime wrap
    @(negedge clk100);
    #1;
    force dut.uptime_q = 32'hFFFF_FFFF;
    #1;
    release dut.uptime_q;
    adv(1);  expect_out("wrap_0", 1'b1, 1'b0, 2'b11, 16'd0, 32'd0);
    adv(1);  expect_out("wrap_1", 1'b1, 1'b0, 2'b11, 16'd0, 32'd1);

    // Loss counter saturation
    @(negedge clk100);
    #1;
    force dut.lock_loss_q = 16'hFFFF;
    #1;
    release dut.lock_loss_q;
    adv(1);  expect_out("sat_pre", 1'b1, 1'b0, 2'b11, 16'hFFFF, 32'd2);
    lose("sat", 16'hFFFF, 16'hFFFF, 32'd4);

    @(negedge clk100);
    #1;
    cmp("drain", "queue_left", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
